uart_pmem_loader: RTL and testbench

UART_PMEM_LOADER -- requirements
Module: uart_pmem_loader

---
 rtl/uart_pmem_loader.sv | 205 ++++++++++++++++++++
 tb/tb_uart_pmem_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pmem_loader.sv
// UART boot loader: receives a length-prefixed word image and writes it over AHB-Lite.
// Optional macro UART_PMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module uart_pmem_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MAX_WORDS    = 2048
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        rx,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        load_active,
  output logic        load_done,
  output logic        load_err
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] HDR0 = 3'd0;
  localparam logic [2:0] HDR1 = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] DONE = 3'd4;
  localparam logic [2:0] ERR  = 3'd5;
`ifdef UART_PMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHK  = 3'd3;
  localparam logic [2:0] LAST = CHK;
`else
  localparam logic [2:0] LAST = DONE;
`endif

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  logic          sync1, sync2, rx_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] bit_clk;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_vld, frame_err;

  logic [2:0]    state;
  logic [7:0]    n_lo;
  logic [15:0]   n_words, word_cnt, hdr_n;
  logic [1:0]    byte_cnt;
  logic [23:0]   word_acc;
  logic [31:0]   wdata_hold;
  logic          aphase, dphase, wr_done;
`ifdef UART_PMEM_LOADER_CHECKSUM_EN
  logic [7:0]    xor_acc;
`endif

  assign HSIZE       = 3'b010;
  assign hdr_n       = {shreg, n_lo};
  assign wr_done     = dphase && HREADY;
  assign load_done   = (state == DONE);
  assign load_err    = (state == ERR);
  assign load_active = (state != DONE && state != ERR) || aphase || dphase;

  // Synchroniser plus one extra flop for falling-edge detection
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  // UART receiver: byte_vld / frame_err pulse for one cycle at the stop-bit centre
  always_ff @(posedge HCLK) begin
    byte_vld  <= 1'b0;
    frame_err <= 1'b0;
    if (HRESET) begin
      rx_state <= RX_IDLE;
      bit_clk  <= '0;
      bit_idx  <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          bit_clk <= '0;
          if (rx_prev && !sync2) rx_state <= RX_START;
        end
        RX_START: begin
          if (bit_clk == HALF_BIT) begin
            bit_clk  <= '0;
            bit_idx  <= '0;
            rx_state <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            bit_clk <= bit_clk + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_clk == FULL_BIT) begin
            bit_clk <= '0;
            shreg   <= {sync2, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            bit_clk <= bit_clk + 1'b1;
          end
        end
        default: begin
          if (bit_clk == FULL_BIT) begin
            bit_clk   <= '0;
            rx_state  <= RX_IDLE;
            byte_vld  <= sync2;
            frame_err <= !sync2;
          end else begin
            bit_clk <= bit_clk + 1'b1;
          end
        end
      endcase
    end
  end

  // Load FSM and AHB master; a started transfer always runs to completion, even into ERR
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= HDR0;
      word_cnt <= '0;
      byte_cnt <= '0;
      aphase   <= 1'b0;
      dphase   <= 1'b0;
      HTRANS   <= TR_IDLE;
      HWRITE   <= 1'b0;
      HADDR    <= BASE_ADDR;
      HWDATA   <= '0;
    end else begin
      if (aphase && HREADY) begin
        aphase <= 1'b0;
        dphase <= 1'b1;
        HTRANS <= TR_IDLE;
        HWRITE <= 1'b0;
        HWDATA <= wdata_hold;
      end
      if (wr_done) begin
        dphase   <= 1'b0;
        word_cnt <= word_cnt + 16'd1;
      end

      if (frame_err && state != DONE && state != ERR) begin
        state <= ERR;
      end else begin
        case (state)
          HDR0: if (byte_vld) begin
            n_lo  <= shreg;
            state <= HDR1;
`ifdef UART_PMEM_LOADER_CHECKSUM_EN
            xor_acc <= shreg;
`endif
          end
          HDR1: if (byte_vld) begin
            n_words <= hdr_n;
`ifdef UART_PMEM_LOADER_CHECKSUM_EN
            xor_acc <= xor_acc ^ shreg;
`endif
            if (hdr_n > 16'(MAX_WORDS)) state <= ERR;
            else if (hdr_n == 16'd0)    state <= LAST;
            else                        state <= DATA;
          end
          DATA: begin
            if (byte_vld) begin
`ifdef UART_PMEM_LOADER_CHECKSUM_EN
              xor_acc <= xor_acc ^ shreg;
`endif
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt != 2'd3) begin
                word_acc <= {shreg, word_acc[23:8]};
              end else if (aphase || dphase) begin
                state <= ERR;
              end else begin
                aphase     <= 1'b1;
                HTRANS     <= TR_NONSEQ;
                HWRITE     <= 1'b1;
                HADDR      <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
                wdata_hold <= {shreg, word_acc};
              end
            end
            if (wr_done && word_cnt == n_words - 16'd1) state <= LAST;
          end
`ifdef UART_PMEM_LOADER_CHECKSUM_EN
          CHK: if (byte_vld) state <= (shreg == xor_acc) ? DONE : ERR;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_pmem_loader.sv
// Directed bench for uart_pmem_loader with a small AHB slave model that logs writes and can stall.
`timescale 1ns/1ps
module tb_uart_pmem_loader;

  localparam int CPB = 16;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        rx = 1'b1;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY = 1'b1;
  logic        load_active, load_done, load_err;

  int checks = 0;
  int failures = 0;
  logic stall_mode = 1'b0;

  // Slave model state, owned by the slave process
  int          wr_cnt = 0;
  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];
  logic        nonseq_seen = 1'b0;
  logic        stall_bad = 1'b0;
  logic [1:0]  ph = 2'd0;
  int          st_cnt = 0;
  logic        data_first = 1'b0;
  logic [31:0] ref_addr = '0, ref_data = '0;

  uart_pmem_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0000_0000), .MAX_WORDS(2048)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .rx(rx),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .load_active(load_active), .load_done(load_done), .load_err(load_err)
  );

  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) begin
    if (HRESET) begin
      ph = 2'd0; HREADY = 1'b1; wr_cnt = 0; nonseq_seen = 1'b0; stall_bad = 1'b0;
    end else begin
      if (ph == 2'd0 && HTRANS == 2'b10) begin
        ph = 2'd1; ref_addr = HADDR; st_cnt = stall_mode ? 5 : 0; nonseq_seen = 1'b1;
      end
      if (ph == 2'd1) begin
        if (HADDR !== ref_addr || HTRANS !== 2'b10 || HWRITE !== 1'b1) stall_bad = 1'b1;
        if (st_cnt > 0) begin
          HREADY = 1'b0; st_cnt--;
        end else begin
          HREADY = 1'b1; ph = 2'd2; data_first = 1'b1; st_cnt = stall_mode ? 5 : 0;
        end
      end else if (ph == 2'd2) begin
        if (data_first) begin
          ref_data = HWDATA; data_first = 1'b0;
        end else if (HWDATA !== ref_data) begin
          stall_bad = 1'b1;
        end
        if (HTRANS !== 2'b00) stall_bad = 1'b1;
        if (st_cnt > 0) begin
          HREADY = 1'b0; st_cnt--;
        end else begin
          HREADY = 1'b1; ph = 2'd0;
          if (wr_cnt < 8) begin
            wr_addr[wr_cnt] = ref_addr; wr_data[wr_cnt] = HWDATA;
          end
          wr_cnt++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    rx = 1'b1; HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    repeat (2) @(negedge HCLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge HCLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge HCLK);
    end
    rx = stop;
    repeat (CPB) @(negedge HCLK);
    rx = 1'b1;
    repeat (CPB) @(negedge HCLK);
  endtask

  logic [7:0] img [0:9];

  task automatic send_image();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 10; i++) begin
      send_byte(img[i], 1'b1);
      x = x ^ img[i];
    end
`ifdef UART_PMEM_LOADER_CHECKSUM_EN
    send_byte(x, 1'b1);
`endif
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(load_done || load_err) && n < 4000) begin
      @(negedge HCLK); n++;
    end
    chk({tag, "_timeout"}, 32'(n >= 4000), 32'd0);
    repeat (20) @(negedge HCLK);
  endtask

  task automatic check_image(input string tag);
    chk({tag, "_wrcnt"}, 32'(wr_cnt), 32'd2);
    chk({tag, "_a0"}, wr_addr[0], 32'h0000_0000);
    chk({tag, "_d0"}, wr_data[0], 32'h1234_5678);
    chk({tag, "_a1"}, wr_addr[1], 32'h0000_0004);
    chk({tag, "_d1"}, wr_data[1], 32'hDEAD_BEEF);
    chk({tag, "_done"}, 32'(load_done), 32'd1);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
    chk({tag, "_active"}, 32'(load_active), 32'd0);
    chk({tag, "_htrans"}, 32'(HTRANS), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_htrans"}, 32'(HTRANS), 32'd0);
    chk({tag, "_hwrite"}, 32'(HWRITE), 32'd0);
    chk({tag, "_haddr"}, HADDR, 32'h0000_0000);
    chk({tag, "_hwdata"}, HWDATA, 32'h0000_0000);
    chk({tag, "_hsize"}, 32'(HSIZE), 32'd2);
    chk({tag, "_active"}, 32'(load_active), 32'd1);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    img[0] = 8'h02; img[1] = 8'h00;
    img[2] = 8'h78; img[3] = 8'h56; img[4] = 8'h34; img[5] = 8'h12;
    img[6] = 8'hEF; img[7] = 8'hBE; img[8] = 8'hAD; img[9] = 8'hDE;

    do_reset();
    check_reset_vals("rst");

    // Basic two-word load with zero-wait slave
    send_image();
    wait_end("basic");
    check_image("basic");

    // Same stream, 5 wait states in every phase
    stall_mode = 1'b1;
    do_reset();
    send_image();
    wait_end("stall");
    check_image("stall");
    chk("stall_stable", 32'(stall_bad), 32'd0);
    stall_mode = 1'b0;

    // Oversized header N=2049
    do_reset();
    send_byte(8'h01, 1'b1);
    send_byte(8'h08, 1'b1);
    wait_end("big");
    chk("big_err", 32'(load_err), 32'd1);
    chk("big_done", 32'(load_done), 32'd0);
    chk("big_nonseq", 32'(nonseq_seen), 32'd0);
    chk("big_active", 32'(load_active), 32'd0);

    // Framing error on the third data byte
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(img[i], 1'b1);
    send_byte(img[4], 1'b0);
    wait_end("frm");
    chk("frm_err", 32'(load_err), 32'd1);
    chk("frm_wrcnt", 32'(wr_cnt), 32'd0);
    chk("frm_htrans", 32'(HTRANS), 32'd0);
    send_byte(img[5], 1'b1);
    chk("frm_sticky", 32'(load_err), 32'd1);
    chk("frm_nonseq", 32'(nonseq_seen), 32'd0);

    // Short low glitch on idle line, then empty image
    do_reset();
    rx = 1'b0;
    repeat (5) @(negedge HCLK);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge HCLK);
    chk("glitch_noerr", 32'(load_err), 32'd0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
`ifdef UART_PMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    wait_end("glitch");
    chk("glitch_done", 32'(load_done), 32'd1);
    chk("glitch_err", 32'(load_err), 32'd0);
    chk("glitch_wrcnt", 32'(wr_cnt), 32'd0);

    // Reset during the second byte of word 1, then a full reload
    do_reset();
    for (int i = 0; i < 7; i++) send_byte(img[i], 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge HCLK);
    for (int i = 0; i < 4; i++) begin
      rx = img[7][i];
      repeat (CPB) @(negedge HCLK);
    end
    rx = 1'b1; HRESET = 1'b1;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    check_reset_vals("midrst");
    repeat (2 * CPB) @(negedge HCLK);
    send_image();
    wait_end("reload");
    check_image("reload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
